// File: rtl/sobel_frame_sequencer_pkg.sv
// Shared constants and state encoding for the Sobel frame sequencer.
package sobel_frame_sequencer_pkg;

  localparam int unsigned IMG_WIDTH_DEF   = 160;
  localparam int unsigned IMG_HEIGHT_DEF  = 120;
  localparam int unsigned PIXEL_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF  = 15;

  // Slots per window: filler + 9 pixels, then filler + 3 pixels per new column
  localparam int unsigned SLOTS_FIRST = 10;
  localparam int unsigned SLOTS_NEXT  = 4;

  typedef enum logic [2:0] {
    IDLE,
    FIRST_WIN,
    NEXT_COL,
    BAND_GAP,
    FLUSH
  } state_t;

endpackage

// File: rtl/sobel_frame_sequencer_if.sv
// Image RAM read port, Sobel engine link and result RAM write port.
interface sobel_frame_sequencer_if #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned PIXEL_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]  rd_addr_o;
  logic                   rd_en_o;
  logic [PIXEL_WIDTH-1:0] rd_data_i;
  logic                   sobel_start_o;
  logic [PIXEL_WIDTH-1:0] sobel_px_o;
  logic                   sobel_px_ready_i;
  logic [PIXEL_WIDTH-1:0] sobel_px_i;
  logic                   wr_en_o;
  logic [ADDR_WIDTH-1:0]  wr_addr_o;
  logic [PIXEL_WIDTH-1:0] wr_data_o;

  modport master (
    output rd_addr_o, rd_en_o, sobel_start_o, sobel_px_o,
           wr_en_o, wr_addr_o, wr_data_o,
    input  rd_data_i, sobel_px_ready_i, sobel_px_i
  );

  modport slave (
    input  rd_addr_o, rd_en_o, sobel_start_o, sobel_px_o,
           wr_en_o, wr_addr_o, wr_data_o,
    output rd_data_i, sobel_px_ready_i, sobel_px_i
  );

endinterface

// File: rtl/sobel_result_writer.sv
// Collects engine results while busy and writes them to consecutive result RAM addresses.
module sobel_result_writer #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   clear_i,
  input  logic                   busy_i,
  input  logic                   px_ready_i,
  input  logic [PIXEL_WIDTH-1:0] px_i,
  output logic                   wr_en_o,
  output logic [ADDR_WIDTH-1:0]  wr_addr_o,
  output logic [PIXEL_WIDTH-1:0] wr_data_o,
  output logic [ADDR_WIDTH-1:0]  count_o
);

  logic [ADDR_WIDTH-1:0] count_q;
  logic                  accept;

  assign accept = px_ready_i & busy_i;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      count_q   <= '0;
    end else begin
      wr_en_o <= accept;
      if (clear_i) begin
        count_q <= '0;
      end else if (accept) begin
        wr_addr_o <= count_q;
        wr_data_o <= px_i;
        count_q   <= count_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame driver for the Sobel engine: streams 3x3 windows band by band and collects results.
module sobel_frame_sequencer
  import sobel_frame_sequencer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT  = IMG_HEIGHT_DEF,
  parameter int unsigned PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    nreset_i,
  input  logic                    frame_start_i,
  output logic                    busy_o,
  output logic                    done_o,
  sobel_frame_sequencer_if.master bus
);

  localparam int unsigned CW        = $clog2(IMG_WIDTH);
  localparam int unsigned RW        = $clog2(IMG_HEIGHT);
  localparam int unsigned RESULTS   = (IMG_HEIGHT - 2) * (IMG_WIDTH - 2);
  localparam int unsigned LAST_BAND = IMG_HEIGHT - 3;

  state_t                state_q, state_d;
  logic [3:0]            slot_q, slot_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [1:0]            win_row, win_col;
  logic                  start_frame;
  logic [ADDR_WIDTH-1:0] rd_row, rd_col;
  logic [ADDR_WIDTH-1:0] result_count;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    slot_d            = slot_q;
    row_d             = row_q;
    col_d             = col_q;
    start_frame       = 1'b0;
    done_o            = 1'b0;
    win_row           = '0;
    win_col           = '0;
    bus.rd_en_o       = 1'b0;
    bus.sobel_start_o = 1'b0;
    bus.sobel_px_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          start_frame = 1'b1;
          state_d     = FIRST_WIN;
          slot_d      = '0;
          row_d       = '0;
          col_d       = '0;
        end
      end
      FIRST_WIN: begin
        bus.sobel_start_o = 1'b1;
        // Read for slot s+1 is issued in cycle s; slot index maps to (pix, vector)
        win_row     = 2'(slot_q % 4'd3);
        win_col     = 2'(slot_q / 4'd3);
        bus.rd_en_o = (slot_q < 4'(SLOTS_FIRST - 1));
        if (slot_q != '0) bus.sobel_px_o = bus.rd_data_i;
        if (slot_q == 4'(SLOTS_FIRST - 1)) begin
          slot_d  = '0;
          col_d   = CW'(3);
          state_d = (IMG_WIDTH == 3) ? BAND_GAP : NEXT_COL;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      NEXT_COL: begin
        bus.sobel_start_o = 1'b1;
        win_row     = slot_q[1:0];
        bus.rd_en_o = (slot_q < 4'(SLOTS_NEXT - 1));
        if (slot_q != '0) bus.sobel_px_o = bus.rd_data_i;
        if (slot_q == 4'(SLOTS_NEXT - 1)) begin
          slot_d = '0;
          if (col_q == CW'(IMG_WIDTH - 1)) state_d = BAND_GAP;
          else                             col_d   = col_q + CW'(1);
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      BAND_GAP: begin
        row_d  = row_q + RW'(1);
        col_d  = '0;
        slot_d = '0;
        // r+1 <= H-3 rewritten as r < H-3 so the row counter never overflows
        state_d = (row_q < RW'(LAST_BAND)) ? FIRST_WIN : FLUSH;
      end
      FLUSH: begin
        if ((result_count == ADDR_WIDTH'(RESULTS)) && !bus.wr_en_o) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  assign rd_row        = ADDR_WIDTH'(row_q) + ADDR_WIDTH'(win_row);
  assign rd_col        = ADDR_WIDTH'(col_q) + ADDR_WIDTH'(win_col);
  assign bus.rd_addr_o = bus.rd_en_o ? (rd_row * ADDR_WIDTH'(IMG_WIDTH) + rd_col) : '0;

  sobel_result_writer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_writer (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .clear_i   (start_frame),
    .busy_i    (busy_o),
    .px_ready_i(bus.sobel_px_ready_i),
    .px_i      (bus.sobel_px_i),
    .wr_en_o   (bus.wr_en_o),
    .wr_addr_o (bus.wr_addr_o),
    .wr_data_o (bus.wr_data_o),
    .count_o   (result_count)
  );

endmodule
